// File: rtl/matvec_pkg.sv
// Shared types and sizing helpers for the matvec_systolic engine.
package matvec_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} matvec_state_t;

   localparam int DEF_ROWS = 8;
   localparam int DEF_COLS = 8;

   function automatic int ldcnt_w(input int rows, input int cols);
      return $clog2(cols + rows * cols + 1);
   endfunction

   function automatic int runcnt_w(input int rows, input int cols);
      return $clog2(rows + cols);
   endfunction

   // Index width that never collapses to zero bits for single-entry arrays.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int LDCNT_W  = ldcnt_w(DEF_ROWS, DEF_COLS);
   localparam int RUNCNT_W = runcnt_w(DEF_ROWS, DEF_COLS);

endpackage

// File: rtl/matvec_mac.sv
// One multiply-accumulate lane of the systolic row.
// MATVEC_SIGNED_EN selects two's-complement operands; default is unsigned.
module matvec_mac
   import matvec_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 24
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [AW-1:0] acc
);

   logic [AW-1:0] prod_ext;

`ifdef MATVEC_SIGNED_EN
   logic signed [2*DW-1:0] prod;
   // Operands widened first so the low 2*DW bits hold the exact signed product.
   assign prod     = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
   assign prod_ext = AW'(prod);
`else
   logic [2*DW-1:0] prod;
   assign prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
   assign prod_ext = AW'(prod);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + prod_ext;
   end

endmodule

// File: rtl/matvec_systolic.sv
// Matrix-vector engine: streams B then row-major A into buffers, runs a skewed MAC row.
// Build option MATVEC_SIGNED_EN (in matvec_mac) switches to signed operands.
module matvec_systolic
   import matvec_pkg::*;
#(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int DW   = 8,
   parameter int AW   = 24
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               start,
   input  logic               ld_valid,
   input  logic [DW-1:0]      ld_data,
   output logic               ld_ready,
   output logic               busy,
   output logic               done,
   output logic               res_valid,
   output logic [ROWS*AW-1:0] result
);

   localparam int LD_W  = ldcnt_w(ROWS, COLS);
   localparam int RUN_W = runcnt_w(ROWS, COLS);
   localparam int COL_W = idx_w(COLS);
   localparam int ROW_W = idx_w(ROWS);

   localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(COLS + ROWS * COLS - 1);
   // One extra flush cycle covers the registered buffer read ahead of the MACs.
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(ROWS + COLS - 1);

   matvec_state_t     state_reg, state_next;
   logic [LD_W-1:0]   ld_cnt_reg;
   logic [COL_W-1:0]  wr_col_reg;
   logic [ROW_W-1:0]  wr_row_reg;
   logic [RUN_W-1:0]  t_reg;
   logic              done_reg;
   logic              start_ok, beat, a_phase, acc_clr;

   logic [DW-1:0]     b_mem [COLS];
   logic [DW-1:0]     b_pipe_reg [ROWS];

   assign start_ok  = start && !clr && (state_reg == IDLE || state_reg == DONE);
   assign ld_ready  = (state_reg == LOAD) && !clr;
   assign beat      = ld_valid && ld_ready;
   assign a_phase   = int'(ld_cnt_reg) >= COLS;
   assign acc_clr   = clr || start_ok;
   assign busy      = (state_reg == LOAD) || (state_reg == RUN);
   assign res_valid = (state_reg == DONE);
   assign done      = done_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (clr) begin
         state_next = IDLE;
      end else begin
         unique case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (beat && ld_cnt_reg == LD_LAST) state_next = RUN;
            RUN:     if (t_reg == RUN_LAST) state_next = DONE;
            DONE:    if (start) state_next = LOAD;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_cnt_reg <= '0;
         wr_col_reg <= '0;
         wr_row_reg <= '0;
         t_reg      <= '0;
         done_reg   <= 1'b0;
      end else if (clr) begin
         ld_cnt_reg <= '0;
         wr_col_reg <= '0;
         wr_row_reg <= '0;
         t_reg      <= '0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= (state_reg == RUN) && (t_reg == RUN_LAST);
         t_reg    <= (state_reg == RUN) ? t_reg + RUN_W'(1) : '0;
         if (start_ok) begin
            ld_cnt_reg <= '0;
            wr_col_reg <= '0;
            wr_row_reg <= '0;
         end else if (beat) begin
            ld_cnt_reg <= ld_cnt_reg + LD_W'(1);
            if (wr_col_reg == COL_W'(COLS - 1)) begin
               wr_col_reg <= '0;
               if (a_phase)
                  wr_row_reg <= wr_row_reg + ROW_W'(1);
            end else begin
               wr_col_reg <= wr_col_reg + COL_W'(1);
            end
         end
      end
   end

   // B buffer read feeds stage 0; each further stage delays B one lane's worth of skew.
   always_ff @(posedge clk) begin
      if (beat && !a_phase)
         b_mem[wr_col_reg] <= ld_data;
      if (state_reg == RUN && int'(t_reg) < COLS)
         b_pipe_reg[0] <= b_mem[COL_W'(t_reg)];
      for (int i = 1; i < ROWS; i++)
         b_pipe_reg[i] <= b_pipe_reg[i-1];
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
      logic [DW-1:0] a_mem [COLS];
      logic [DW-1:0] a_rd_reg;
      logic          en_reg;
      logic          lane_en;
      logic [AW-1:0] acc;

      assign lane_en = (state_reg == RUN) && (int'(t_reg) >= gi) && (int'(t_reg) < gi + COLS);

      always_ff @(posedge clk) begin
         if (beat && a_phase && wr_row_reg == ROW_W'(gi))
            a_mem[wr_col_reg] <= ld_data;
         if (lane_en)
            a_rd_reg <= a_mem[COL_W'(int'(t_reg) - gi)];
      end

      // Gated by clr so a read already in flight cannot land after an abort.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            en_reg <= 1'b0;
         else
            en_reg <= lane_en && !clr;
      end

      matvec_mac #(.DW(DW), .AW(AW)) u_mac (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (acc_clr),
         .en    (en_reg),
         .a     (a_rd_reg),
         .b     (b_pipe_reg[gi]),
         .acc   (acc)
      );

      assign result[gi*AW +: AW] = acc;
   end

endmodule

// File: tb/tb_matvec_systolic.sv
// Scoreboard bench for matvec_systolic: expected vectors queued at job start, checked at done.
module tb_matvec_systolic;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int DW   = 8;
   localparam int AW   = 24;
   localparam int NBEATS = COLS + ROWS * COLS;

   typedef logic [ROWS*AW-1:0] res_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               clr = 1'b0;
   logic               start = 1'b0;
   logic               ld_valid = 1'b0;
   logic [DW-1:0]      ld_data = '0;
   logic               ld_ready;
   logic               busy;
   logic               done;
   logic               res_valid;
   logic [ROWS*AW-1:0] result;

   int   errors = 0;
   int   checks = 0;
   int   job_no = 0;
   res_t exp_q[$];

   logic [DW-1:0] a_m [ROWS][COLS];
   logic [DW-1:0] b_v [COLS];

   matvec_systolic #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .start     (start),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .busy      (busy),
      .done      (done),
      .res_valid (res_valid),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic res_t model();
      res_t   r;
      longint acc;
      r = '0;
      for (int i = 0; i < ROWS; i++) begin
         acc = 0;
         for (int k = 0; k < COLS; k++) begin
`ifdef MATVEC_SIGNED_EN
            acc += longint'($signed(a_m[i][k])) * longint'($signed(b_v[k]));
`else
            acc += longint'(a_m[i][k]) * longint'(b_v[k]);
`endif
         end
         r[i*AW +: AW] = acc[AW-1:0];
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] beat_val(input int i);
      if (i < COLS) return b_v[i];
      return a_m[(i - COLS) / COLS][(i - COLS) % COLS];
   endfunction

   task automatic fill_random();
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < COLS; k++)
            a_m[r][k] = DW'($urandom_range(255));
      for (int k = 0; k < COLS; k++)
         b_v[k] = DW'($urandom_range(255));
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic load_all(input int gap_pct);
      int idx = 0;
      int guard = 0;
      int ready_low = 0;
      while (idx < NBEATS && guard < 5000) begin
         if (!ld_ready) ready_low++;
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            ld_valid = 1'b0;
         end else begin
            ld_valid = 1'b1;
            ld_data  = beat_val(idx);
         end
         step();
         if (ld_valid) idx++;
         guard++;
      end
      ld_valid = 1'b0;
      check("ld_ready_held", 64'(ready_low), 64'd0);
      check("beats_taken", 64'(idx), 64'(NBEATS));
      check("ld_ready_after_load", 64'(ld_ready), 64'd0);
      check("busy_in_run", 64'(busy), 64'd1);
   endtask

   task automatic wait_done(input int max_cyc, output int lat);
      bit   found = 0;
      res_t e;
      lat = 0;
      while (!found && lat < max_cyc) begin
         step();
         lat++;
         if (done) found = 1;
      end
      if (!found) begin
         check("done_timeout", 64'd0, 64'd1);
         return;
      end
      job_no++;
      check("res_valid_at_done", 64'(res_valid), 64'd1);
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         for (int r = 0; r < ROWS; r++)
            check($sformatf("job%0d_lane%0d", job_no, r), 64'(result[r*AW +: AW]), 64'(e[r*AW +: AW]));
      end
      $display("job %0d done latency=%0d lane0=%0d lane%0d=%0d", job_no, lat,
               result[0 +: AW], ROWS - 1, result[(ROWS-1)*AW +: AW]);
      step();
      check("done_one_cycle", 64'(done), 64'd0);
      check("res_valid_held", 64'(res_valid), 64'd1);
   endtask

   task automatic run_job(input int gap_pct, input bit chk_lat);
      int lat;
      exp_q.push_back(model());
      do_start();
      load_all(gap_pct);
      wait_done(100, lat);
      if (chk_lat) check("latency", 64'(lat), 64'(ROWS + COLS));
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
      check({tag, "_ld_ready"}, 64'(ld_ready), 64'd0);
      check({tag, "_result_nz"}, 64'(result != '0), 64'd0);
   endtask

   initial begin
      int lat;
      int pulses;
      logic [63:0] ff_lane;

      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst_n = 1'b1;
      step();

      // Identity matrix, B = 1..8: lane r = r+1, latency ROWS+COLS
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < COLS; k++)
            a_m[r][k] = (r == k) ? DW'(1) : DW'(0);
      for (int k = 0; k < COLS; k++) b_v[k] = DW'(k + 1);
      run_job(0, 1'b1);
      for (int r = 0; r < ROWS; r++)
         check($sformatf("ident_lane%0d", r), 64'(result[r*AW +: AW]), 64'(r + 1));

      // All operands 0xFF
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < COLS; k++) a_m[r][k] = 8'hFF;
      for (int k = 0; k < COLS; k++) b_v[k] = 8'hFF;
`ifdef MATVEC_SIGNED_EN
      ff_lane = 64'd8;
`else
      ff_lane = 64'd520200;
`endif
      run_job(0, 1'b1);
      for (int r = 0; r < ROWS; r++)
         check($sformatf("ff_lane%0d", r), 64'(result[r*AW +: AW]), ff_lane);

      // Gapped load, A[r][k] = r+k, B = 1: lane r = 8r+28
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < COLS; k++) a_m[r][k] = DW'(r + k);
      for (int k = 0; k < COLS; k++) b_v[k] = DW'(1);
      run_job(40, 1'b0);
      for (int r = 0; r < ROWS; r++)
         check($sformatf("gap_lane%0d", r), 64'(result[r*AW +: AW]), 64'(8 * r + 28));

      // start pulsed during RUN is ignored; exactly one done pulse
      fill_random();
      exp_q.push_back(model());
      do_start();
      load_all(0);
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_in_run_busy", 64'(busy), 64'd1);
      wait_done(100, lat);
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (done) pulses++;
      end
      check("extra_done_pulses", 64'(pulses), 64'd0);

      // start in DONE: res_valid drops on the same edge, new job correct
      fill_random();
      exp_q.push_back(model());
      do_start();
      check("restart_res_valid", 64'(res_valid), 64'd0);
      check("restart_busy", 64'(busy), 64'd1);
      load_all(30);
      wait_done(100, lat);

      // clr at RUN t=3 aborts the job
      fill_random();
      do_start();
      load_all(0);
      step();
      step();
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      check_idle_zero("clr_abort");
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (done) pulses++;
      end
      check("clr_no_done", 64'(pulses), 64'd0);

      // clr and start together: stays IDLE
      clr = 1'b1;
      start = 1'b1;
      step();
      check("clr_start_busy", 64'(busy), 64'd0);
      clr = 1'b0;
      start = 1'b0;
      step();
      check("clr_start_still_idle", 64'(busy), 64'd0);

      // clr during LOAD blocks the beat presented with it
      fill_random();
      do_start();
      ld_valid = 1'b1;
      clr = 1'b1;
      #1;
      check("clr_ld_ready", 64'(ld_ready), 64'd0);
      step();
      clr = 1'b0;
      ld_valid = 1'b0;
      check("clr_load_busy", 64'(busy), 64'd0);

      // async reset mid-LOAD after a completed job left results valid
      fill_random();
      run_job(0, 1'b0);
      fill_random();
      do_start();
      for (int i = 0; i < 20; i++) begin
         ld_valid = 1'b1;
         ld_data  = beat_val(i);
         step();
      end
      ld_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_zero("async_rst");
      step();
      rst_n = 1'b1;
      step();
      fill_random();
      run_job(20, 1'b0);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
